// File: rtl/fixed_point_pkg.sv
// Shared Q16.16 fixed-point types, limits and saturation helper for the
// vertex-transform datapath.
package fixed_point_pkg;

  localparam int FP_W       = 32;
  localparam int fraction_w = 16;

  typedef logic signed [FP_W-1:0] fixed_point_t;
  // Two guard bits: a sum of four sign-extended W-bit terms cannot wrap.
  typedef logic signed [FP_W+1:0] fp_acc_t;

  localparam fixed_point_t FP_MAX = {1'b0, {(FP_W-1){1'b1}}};
  localparam fixed_point_t FP_MIN = {1'b1, {(FP_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_OUT
  } dot_state_e;

  typedef struct packed {
    fixed_point_t value;
    logic         overflow;
  } fp_sat_t;

  function automatic fp_sat_t fp_saturate(input fp_acc_t acc);
    fp_sat_t s;
    if (acc > fp_acc_t'(FP_MAX)) begin
      s.value    = FP_MAX;
      s.overflow = 1'b1;
    end else if (acc < fp_acc_t'(FP_MIN)) begin
      s.value    = FP_MIN;
      s.overflow = 1'b1;
    end else begin
      s.value    = acc[FP_W-1:0];
      s.overflow = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/fixed_point_mul.sv
// Combinational Q16.16 multiplier: full signed product, floor-shifted by the
// fraction width, truncated to W bits, with a range flag.
module fixed_point_mul
  import fixed_point_pkg::*;
(
  input  fixed_point_t i_a,
  input  fixed_point_t i_b,
  output fixed_point_t o_product,
  output logic         o_overflow
);

  logic signed [2*FP_W-1:0] w_a_ext;
  logic signed [2*FP_W-1:0] w_b_ext;
  logic signed [2*FP_W-1:0] w_full;
  logic signed [2*FP_W-1:0] w_shifted;

  assign w_a_ext   = {{FP_W{i_a[FP_W-1]}}, i_a};
  assign w_b_ext   = {{FP_W{i_b[FP_W-1]}}, i_b};
  assign w_full    = w_a_ext * w_b_ext;
  // Arithmetic shift rounds toward minus infinity.
  assign w_shifted = w_full >>> fraction_w;

  assign o_product  = w_shifted[FP_W-1:0];
  assign o_overflow = (w_shifted[2*FP_W-1:FP_W-1] != {(FP_W+1){w_shifted[FP_W-1]}});

endmodule

// File: rtl/fixed_point_dot4.sv
// Sequential fixed-point dot product: one shared multiplier walks N_TERMS
// latched operand pairs, then a saturated result waits on a valid/ready output.
module fixed_point_dot4
  import fixed_point_pkg::*;
#(
  parameter int N_TERMS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  fixed_point_t a [N_TERMS],
  input  fixed_point_t b [N_TERMS],
  output logic         out_valid,
  input  logic         out_ready,
  output fixed_point_t result,
  output logic         overflow
);

  localparam int IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

  dot_state_e     r_state;
  dot_state_e     w_state_next;
  fixed_point_t   r_a [N_TERMS];
  fixed_point_t   r_b [N_TERMS];
  logic [IDX_W-1:0] r_idx;
  fp_acc_t        r_acc;
  fp_acc_t        w_sum;
  fixed_point_t   w_product;
  fp_sat_t        w_sat;
  logic           w_accept;
  logic           w_mul_overflow_unused;

  assign in_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  fixed_point_mul u_mul (
    .i_a        (r_a[r_idx]),
    .i_b        (r_b[r_idx]),
    .o_product  (w_product),
    .o_overflow (w_mul_overflow_unused)
  );

  assign w_sum = r_acc + fp_acc_t'(w_product);
  assign w_sat = fp_saturate(w_sum);

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)            w_state_next = ST_ACC;
      ST_ACC:  if (r_idx == LAST_IDX)   w_state_next = ST_OUT;
      ST_OUT:  if (out_ready)           w_state_next = ST_IDLE;
      default:                          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand registers are reset too; an abandoned transaction must
      // leave no stale operands behind, and the array is only a few words.
      r_a       <= '{default: '0};
      r_b       <= '{default: '0};
      r_idx     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ST_ACC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            result    <= w_sat.value;
            overflow  <= w_sat.overflow;
            out_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
